mutative_predictor: RTL

MUTATIVE_PREDICTOR -- requirements
Module: mutative_predictor

---
 rtl/mutative_predictor.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/mutative_predictor.sv
// Mutative predictor: counts hits/misses over fixed access windows and asks the
// cache controller to grow or shrink its way configuration when the miss rate
// is high or low. After an accepted request it backs off for a cooldown period
// so the controller's change can settle before the next measurement.
//
// Handshake: setup_valid is a registered output that rises when a request is
// raised and stays high, with setup_update held constant, until a cycle where
// setup_valid & setup_ready are both 1 (the transfer). setup_ready has no
// effect while setup_valid is 0. Only rst can drop a request without transfer.
module mutative_predictor #(
  parameter int WINDOW   = 64,
  parameter int MISS_HI  = 16,
  parameter int MISS_LO  = 4,
  parameter int COOLDOWN = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           access_valid,
  input  logic                           access_hit,
  input  logic                           flush_stall,
  input  logic [1:0]                     setup,
  output logic                           setup_valid,
  output logic                           setup_update,
  input  logic                           setup_ready,
  output logic [$clog2(WINDOW+1)-1:0]    window_misses,
  output logic [1:0]                     dbg_state
);

  localparam int CW  = $clog2(WINDOW + 1);
  localparam int CDW = (COOLDOWN > 1) ? $clog2(COOLDOWN) : 1;

  localparam logic [CW-1:0]  WINDOW_LAST = CW'(WINDOW);
  localparam logic [CW-1:0]  HI_THRESH   = CW'(MISS_HI);
  localparam logic [CW-1:0]  LO_THRESH   = CW'(MISS_LO);
  localparam logic [CDW-1:0] COOL_INIT   = CDW'(COOLDOWN - 1);

  typedef enum logic [1:0] {
    S_COUNT = 2'd0,
    S_REQ   = 2'd1,
    S_COOL  = 2'd2
  } state_t;

  state_t         r_state;
  logic [CW-1:0]  r_acc_cnt;
  logic [CW-1:0]  r_miss_cnt;
  logic [CDW-1:0] r_cool_cnt;
  logic           r_update;
  logic [CW-1:0]  r_win_misses;

  state_t         w_state_nxt;
  logic [CW-1:0]  w_acc_nxt;
  logic [CW-1:0]  w_miss_nxt;
  logic [CDW-1:0] w_cool_nxt;
  logic           w_update_nxt;
  logic [CW-1:0]  w_win_nxt;

  logic           w_count_en;
  logic [CW-1:0]  w_acc_inc;
  logic [CW-1:0]  w_miss_inc;
  logic           w_window_done;
  logic           w_grow;
  logic           w_shrink;

  // Counting qualifiers and the evaluation decision for the access on this edge.
  // The decision uses the incremented miss count so the closing access is included.
  always_comb begin
    w_count_en    = access_valid && !flush_stall && (r_state == S_COUNT);
    w_acc_inc     = r_acc_cnt + CW'(1);
    w_miss_inc    = r_miss_cnt + {{(CW-1){1'b0}}, !access_hit};
    w_window_done = w_count_en && (w_acc_inc == WINDOW_LAST);
    // Saturated configurations never produce a request in that direction.
    w_grow        = (w_miss_inc >= HI_THRESH) && (setup != 2'd3);
    w_shrink      = (w_miss_inc <= LO_THRESH) && (setup != 2'd0);
  end

  // Next-state and next-counter logic for the three-state request FSM.
  always_comb begin
    w_state_nxt  = r_state;
    w_acc_nxt    = r_acc_cnt;
    w_miss_nxt   = r_miss_cnt;
    w_cool_nxt   = r_cool_cnt;
    w_update_nxt = r_update;
    w_win_nxt    = r_win_misses;
    case (r_state)
      S_COUNT: begin
        if (w_count_en) begin
          if (w_window_done) begin
            w_acc_nxt  = '0;
            w_miss_nxt = '0;
            w_win_nxt  = w_miss_inc;
            if (w_grow) begin
              w_state_nxt  = S_REQ;
              w_update_nxt = 1'b1;
            end else if (w_shrink) begin
              w_state_nxt  = S_REQ;
              w_update_nxt = 1'b0;
            end
          end else begin
            w_acc_nxt  = w_acc_inc;
            w_miss_nxt = w_miss_inc;
          end
        end
      end
      S_REQ: begin
        // Payload is frozen here; a setup change does not alter it.
        if (setup_ready) begin
          w_state_nxt = S_COOL;
          w_cool_nxt  = COOL_INIT;
        end
      end
      S_COOL: begin
        // Decrements regardless of flush_stall so the back-off is a fixed length.
        if (r_cool_cnt == '0) begin
          w_state_nxt = S_COUNT;
          w_acc_nxt   = '0;
          w_miss_nxt  = '0;
        end else begin
          w_cool_nxt = r_cool_cnt - CDW'(1);
        end
      end
      default: begin
        w_state_nxt = S_COUNT;
      end
    endcase
  end

  // State and counter registers with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= S_COUNT;
      r_acc_cnt    <= '0;
      r_miss_cnt   <= '0;
      r_cool_cnt   <= '0;
      r_update     <= 1'b0;
      r_win_misses <= '0;
    end else begin
      r_state      <= w_state_nxt;
      r_acc_cnt    <= w_acc_nxt;
      r_miss_cnt   <= w_miss_nxt;
      r_cool_cnt   <= w_cool_nxt;
      r_update     <= w_update_nxt;
      r_win_misses <= w_win_nxt;
    end
  end

  assign setup_valid   = (r_state == S_REQ);
  assign setup_update  = r_update;
  assign window_misses = r_win_misses;
  assign dbg_state     = r_state;

endmodule
